axi4_lite_reg_slave: RTL and testbench
======================================

// Module: axi4_lite_reg_slave
// PURPOSE
//  AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers to the SoC bus.
//  Sits behind the interconnect next to data memory; the CPU-side axi4_lite_master reaches it.
//  Flat register outputs drive peripheral control fields in hardware.
//  Independent AW/W capture; one outstanding write and one outstanding read.
// PARAMETERS
//  ADDR_WIDTH  32  AXI address width
//  DATA_WIDTH  32  AXI data width; only 32 supported
//  NUM_REGS    8   register count, power of 2, >=2; byte map 0 .. NUM_REGS*4-1
// PORTS
//  clk            in   1                  single clock, rising edge
//  rst_n          in   1                  asynchronous, active-low reset
//  S_AXI_AWADDR   in   ADDR_WIDTH         write address
//  S_AXI_AWVALID  in   1                  write address valid
//  S_AXI_AWREADY  out  1                  write address ready
//  S_AXI_WDATA    in   DATA_WIDTH         write data
//  S_AXI_WSTRB    in   4                  byte strobes; bit i selects byte i
//  S_AXI_WVALID   in   1                  write data valid
//  S_AXI_WREADY   out  1                  write data ready
//  S_AXI_BRESP    out  2                  write response
//  S_AXI_BVALID   out  1                  write response valid
//  S_AXI_BREADY   in   1                  write response ready
//  S_AXI_ARADDR   in   ADDR_WIDTH         read address
//  S_AXI_ARVALID  in   1                  read address valid
//  S_AXI_ARREADY  out  1                  read address ready
//  S_AXI_RDATA    out  DATA_WIDTH         read data
//  S_AXI_RRESP    out  2                  read response
//  S_AXI_RVALID   out  1                  read data valid
//  S_AXI_RREADY   in   1                  read data ready
//  reg_out        out  NUM_REGS*32        register contents; reg k at [32k+31:32k]
//  reg_wr_pulse   out  NUM_REGS           1-cycle pulse per register on commit
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - Registers, RDATA, BRESP, RRESP and reg_wr_pulse all 0.
//   - BVALID and RVALID 0; AW/W holding flags cleared.
//   - AWREADY, WREADY and ARREADY read 1.
//   - Reset mid-transaction drops every in-flight AW, W, B and R. No partial commit.
//  Decode:
//   - Index = ADDR[$clog2(NUM_REGS)+1:2]; ADDR[1:0] ignored.
//   - Address is out of range when ADDR >= NUM_REGS*4.
//  Write channel:
//   - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
//   - AW and W handshake in any order or the same cycle; each is latched into its own holding register.
//   - Commit at the first rising edge where both are held; the edge after the later handshake.
//   - Commit updates bytes with WSTRB=1 only; a WSTRB=0000 commit changes no data.
//   - reg_wr_pulse[idx] is 1 for the cycle after commit; it fires for any in-range commit.
//   - BVALID rises on the commit edge. BRESP holds until the B handshake (BVALID && BREADY).
//   - Both holding flags clear on commit; new AW/W are accepted only after the B handshake.
//  Read channel:
//   - ARREADY = !RVALID. The AR handshake edge loads RDATA/RRESP and sets RVALID (0-cycle latency).
//   - RDATA and RRESP stay stable until RVALID && RREADY.
//   - The next AR is accepted in the cycle after the R handshake.
//  Read/write same register on the same edge: read returns the pre-commit value.
//  Read and write paths are fully independent; no cross-channel ordering.
//  Responses use only OKAY(00) and SLVERR(10).
// CONFIGURATION
//  AXI_REG_SLVERR_EN defined:
//   - Out-of-range write: no register change, no pulse, BRESP=SLVERR.
//   - Out-of-range read: RDATA=0, RRESP=SLVERR.
//  AXI_REG_SLVERR_EN undefined:
//   - Same data behaviour, but the response is always OKAY.
// STRUCTURE
//  Package axi4_lite_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_t typedef.
//  Same package: WORD_BYTES=4 constant and a word-index helper function.
//  Sub-module axi4_lite_reg_bank: storage, byte-strobe write, async read mux, wr pulses.
//  Top level holds the AW/W holding registers and the B and R response logic.
// TESTING
//  1. AW+W same cycle, 0x04 / 0xAABBCCDD / WSTRB=1111:
//     BVALID next edge, BRESP=00, reg_wr_pulse[1]=1 for 1 cycle.
//     Read 0x04 -> RDATA=0xAABBCCDD, RRESP=00.
//  2. Reg 1 = 0xAABBCCDD; write 0x11223344 with WSTRB=0011 -> read 0x04 returns 0xAABB3344.
//  3. W at 0x08 3 cycles before AW: WREADY=0 while held; BVALID one edge after AW handshake.
//  4. BREADY low 5 cycles: BVALID and BRESP stable; AWREADY=WREADY=0 throughout.
//  5. Read 0x0C with RREADY low 4 cycles: RDATA stable, ARREADY=0 until the R handshake.
//  6. Write+read 0x100 (NUM_REGS=8):
//     With macro: BRESP=10, RRESP=10, RDATA=0, no reg change.
//     Without macro: both responses 00.
//  7. rst_n low mid-write after AW only: BVALID=0, regs=0, all READYs=1; a fresh write completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes and word-decode helpers for the AXI4-Lite register slave
//
// Purpose: response encodings, the register word size and the byte-address to word-index helper.
// Ports:   none (package).
// Config:  the AXI_REG_SLVERR_EN macro is consumed by axi4_lite_reg_slave, not here.
package axi4_lite_pkg;

   typedef logic [1:0] RESP_t;

   localparam RESP_t RESP_OKAY   = 2'b00;
   localparam RESP_t RESP_SLVERR = 2'b10;

   localparam int WORD_BYTES = 4;

   // Byte address to word index; the low address bits select a byte within the word and are dropped.
   function automatic logic [31:0] word_index(input logic [31:0] addr);
      return addr >> $clog2(WORD_BYTES);
   endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// rtl/axi4_lite_reg_slave_if.sv - AXI4-Lite bus bundle with master and slave views
//
// Purpose: groups the five AXI4-Lite channels (AW, W, B, AR, R) of the register slave.
// Ports:   parameters ADDR_WIDTH, DATA_WIDTH; modport slave (responder side), modport master (requester side).
interface axi4_lite_reg_slave_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
   logic                  S_AXI_AWVALID;
   logic                  S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0] S_AXI_WDATA;
   logic [3:0]            S_AXI_WSTRB;
   logic                  S_AXI_WVALID;
   logic                  S_AXI_WREADY;
   logic [1:0]            S_AXI_BRESP;
   logic                  S_AXI_BVALID;
   logic                  S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
   logic                  S_AXI_ARVALID;
   logic                  S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0] S_AXI_RDATA;
   logic [1:0]            S_AXI_RRESP;
   logic                  S_AXI_RVALID;
   logic                  S_AXI_RREADY;

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
             S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// rtl/axi4_lite_reg_bank.sv - register storage with byte-strobe writes, async read mux and write pulses
//
// Purpose: holds NUM_REGS words, applies strobed writes, exposes all words flat and one word by index.
// Ports:   clk, rst_n (async active-low); wr_en_i, wr_idx_i, wr_data_i, wr_strb_i (commit);
//          rd_idx_i -> rd_data_o (combinational); reg_out (flat contents); reg_wr_pulse (1 cycle per commit).
module axi4_lite_reg_bank
   import axi4_lite_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8,
   parameter int IDX_W      = $clog2(NUM_REGS)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_en_i,
   input  logic [IDX_W-1:0]               wr_idx_i,
   input  logic [DATA_WIDTH-1:0]          wr_data_i,
   input  logic [WORD_BYTES-1:0]          wr_strb_i,
   input  logic [IDX_W-1:0]               rd_idx_i,
   output logic [DATA_WIDTH-1:0]          rd_data_o,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   pulse_q;
   logic [NUM_REGS-1:0]   pulse_d;

   always_comb begin
      regs_d  = regs_q;
      pulse_d = '0;
      if (wr_en_i) begin
         for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_strb_i[b]) begin
               regs_d[wr_idx_i][8*b +: 8] = wr_data_i[8*b +: 8];
            end
         end
         // Pulse marks the commit even when no strobe bit is set.
         pulse_d[wr_idx_i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q  <= '{default: '0};
         pulse_q <= '0;
      end else begin
         regs_q  <= regs_d;
         pulse_q <= pulse_d;
      end
   end

   // Read sees the registered value, so a same-edge read returns pre-commit data.
   assign rd_data_o    = regs_q[rd_idx_i];
   assign reg_wr_pulse = pulse_q;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
      assign reg_out[DATA_WIDTH*k +: DATA_WIDTH] = regs_q[k];
   end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite responder exposing NUM_REGS 32-bit control registers
//
// Purpose: independent AW/W capture, one outstanding write and one outstanding read, B and R response logic.
// Ports:   clk, rst_n (async active-low); s_axi (axi4_lite_reg_slave_if.slave);
//          reg_out (reg k at [32k+31:32k]); reg_wr_pulse (1-cycle pulse per committed register).
// Config:  AXI_REG_SLVERR_EN defined -> out-of-range accesses answer SLVERR; undefined -> always OKAY.
module axi4_lite_reg_slave
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   axi4_lite_reg_slave_if.slave           s_axi,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_WIDTH-1:0] MAP_END = ADDR_WIDTH'(NUM_REGS * WORD_BYTES);

`ifdef AXI_REG_SLVERR_EN
   localparam RESP_t OOR_RESP = RESP_SLVERR;
`else
   localparam RESP_t OOR_RESP = RESP_OKAY;
`endif

   logic                  aw_held_q, aw_held_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
   logic                  w_held_q,  w_held_d;
   logic [DATA_WIDTH-1:0] w_data_q,  w_data_d;
   logic [3:0]            w_strb_q,  w_strb_d;
   logic                  bvalid_q,  bvalid_d;
   RESP_t                 bresp_q,   bresp_d;
   logic                  rvalid_q,  rvalid_d;
   logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
   RESP_t                 rresp_q,   rresp_d;

   logic                  aw_hs, w_hs, ar_hs, commit;
   logic                  wr_in_range, rd_in_range;
   logic [IDX_W-1:0]      wr_idx, rd_idx;
   logic [DATA_WIDTH-1:0] bank_rdata;

   // Once a response is pending nothing new is taken on that side.
   assign s_axi.S_AXI_AWREADY = !aw_held_q && !bvalid_q;
   assign s_axi.S_AXI_WREADY  = !w_held_q && !bvalid_q;
   assign s_axi.S_AXI_ARREADY = !rvalid_q;

   assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
   assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
   assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
   assign commit = aw_held_q && w_held_q;

   assign wr_in_range = aw_addr_q < MAP_END;
   assign rd_in_range = s_axi.S_AXI_ARADDR < MAP_END;
   assign wr_idx      = IDX_W'(word_index(32'(aw_addr_q)));
   assign rd_idx      = IDX_W'(word_index(32'(s_axi.S_AXI_ARADDR)));

   axi4_lite_reg_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .IDX_W      (IDX_W)
   ) u_bank (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en_i      (commit && wr_in_range),
      .wr_idx_i     (wr_idx),
      .wr_data_i    (w_data_q),
      .wr_strb_i    (w_strb_q),
      .rd_idx_i     (rd_idx),
      .rd_data_o    (bank_rdata),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse)
   );

   always_comb begin
      aw_held_d = aw_held_q;
      aw_addr_d = aw_addr_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_addr_d = s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         w_data_d = s_axi.S_AXI_WDATA;
         w_strb_d = s_axi.S_AXI_WSTRB;
      end

      // Commit and a new handshake never coincide: both holding flags are set during commit.
      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_in_range ? RESP_OKAY : OOR_RESP;
      end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
         bvalid_d = 1'b0;
      end

      if (rvalid_q && s_axi.S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_in_range ? bank_rdata : '0;
         rresp_d  = rd_in_range ? RESP_OKAY : OOR_RESP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         aw_addr_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         aw_held_q <= aw_held_d;
         aw_addr_q <= aw_addr_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign s_axi.S_AXI_BVALID = bvalid_q;
   assign s_axi.S_AXI_BRESP  = bresp_q;
   assign s_axi.S_AXI_RVALID = rvalid_q;
   assign s_axi.S_AXI_RDATA  = rdata_q;
   assign s_axi.S_AXI_RRESP  = rresp_q;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - directed self-checking bench for axi4_lite_reg_slave
module tb_axi4_lite_reg_slave;

   logic         clk;
   logic         rst_n;
   logic [255:0] reg_out;
   logic [7:0]   reg_wr_pulse;
   logic [255:0] exp_regs;
   logic [1:0]   oor_resp;
   int           checks;
   int           failures;

   axi4_lite_reg_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi4_lite_reg_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_axi        (bus),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // AW and W in the same cycle; checks commit timing, response and pulse, then completes B.
   task automatic write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp, input logic [7:0] exp_pulse);
      bus.S_AXI_AWADDR  = addr;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = data;
      bus.S_AXI_WSTRB   = strb;
      bus.S_AXI_WVALID  = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk({tag, "_bvalid_pre"}, bus.S_AXI_BVALID, 1'b0);
      step();
      chk({tag, "_bvalid"}, bus.S_AXI_BVALID, 1'b1);
      chk({tag, "_bresp"}, bus.S_AXI_BRESP, exp_resp);
      chk({tag, "_pulse"}, reg_wr_pulse, exp_pulse);
      bus.S_AXI_BREADY = 1'b1;
      step();
      bus.S_AXI_BREADY = 1'b0;
      chk({tag, "_bvalid_done"}, bus.S_AXI_BVALID, 1'b0);
      chk({tag, "_pulse_done"}, reg_wr_pulse, 8'h00);
   endtask

   task automatic read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                       input logic [1:0] exp_resp);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      step();
      bus.S_AXI_ARVALID = 1'b0;
      chk({tag, "_rvalid"}, bus.S_AXI_RVALID, 1'b1);
      chk({tag, "_rdata"}, bus.S_AXI_RDATA, exp_data);
      chk({tag, "_rresp"}, bus.S_AXI_RRESP, exp_resp);
      bus.S_AXI_RREADY = 1'b1;
      step();
      bus.S_AXI_RREADY = 1'b0;
      chk({tag, "_rvalid_done"}, bus.S_AXI_RVALID, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      exp_regs = '0;
`ifdef AXI_REG_SLVERR_EN
      oor_resp = 2'b10;
`else
      oor_resp = 2'b00;
`endif
      rst_n = 1'b0;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_bvalid", bus.S_AXI_BVALID, 1'b0);
      chk("rst_rvalid", bus.S_AXI_RVALID, 1'b0);
      chk("rst_awready", bus.S_AXI_AWREADY, 1'b1);
      chk("rst_wready", bus.S_AXI_WREADY, 1'b1);
      chk("rst_arready", bus.S_AXI_ARREADY, 1'b1);
      chk("rst_regs", reg_out, 256'h0);
      chk("rst_pulse", reg_wr_pulse, 8'h00);
      chk("rst_rdata", bus.S_AXI_RDATA, 32'h0);
      chk("rst_bresp", bus.S_AXI_BRESP, 2'b00);
      rst_n = 1'b1;
      step();

      // 1: AW+W same cycle to reg 1, full strobe
      write("t1", 32'h04, 32'hAABBCCDD, 4'b1111, 2'b00, 8'h02);
      exp_regs[63:32] = 32'hAABBCCDD;
      chk("t1_regs", reg_out, exp_regs);
      read("t1r", 32'h04, 32'hAABBCCDD, 2'b00);

      // 2: partial strobe keeps upper bytes
      write("t2", 32'h04, 32'h11223344, 4'b0011, 2'b00, 8'h02);
      exp_regs[63:32] = 32'hAABB3344;
      read("t2r", 32'h04, 32'hAABB3344, 2'b00);

      // 3: W three cycles ahead of AW, reg 2
      bus.S_AXI_WDATA  = 32'h55667788;
      bus.S_AXI_WSTRB  = 4'b1111;
      bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_WVALID = 1'b0;
      chk("t3_wready_held", bus.S_AXI_WREADY, 1'b0);
      chk("t3_awready", bus.S_AXI_AWREADY, 1'b1);
      step();
      step();
      chk("t3_wready_held2", bus.S_AXI_WREADY, 1'b0);
      chk("t3_bvalid_wait", bus.S_AXI_BVALID, 1'b0);
      bus.S_AXI_AWADDR  = 32'h08;
      bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      chk("t3_bvalid_pre", bus.S_AXI_BVALID, 1'b0);
      step();
      chk("t3_bvalid", bus.S_AXI_BVALID, 1'b1);
      chk("t3_pulse", reg_wr_pulse, 8'h04);
      exp_regs[95:64] = 32'h55667788;
      chk("t3_regs", reg_out, exp_regs);

      // 4: BREADY held low for 5 cycles; a new AW/W is offered but must wait
      bus.S_AXI_AWADDR  = 32'h10;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = 32'hFFFFFFFF;
      bus.S_AXI_WVALID  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_bvalid", bus.S_AXI_BVALID, 1'b1);
         chk("t4_bresp", bus.S_AXI_BRESP, 2'b00);
         chk("t4_awready", bus.S_AXI_AWREADY, 1'b0);
         chk("t4_wready", bus.S_AXI_WREADY, 1'b0);
      end
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b1;
      step();
      bus.S_AXI_BREADY = 1'b0;
      chk("t4_bvalid_done", bus.S_AXI_BVALID, 1'b0);
      chk("t4_awready_done", bus.S_AXI_AWREADY, 1'b1);
      chk("t4_regs", reg_out, exp_regs);
      read("t3r", 32'h08, 32'h55667788, 2'b00);

      // 5: read reg 3 with RREADY held low
      write("t5w", 32'h0C, 32'hDEADBEEF, 4'b1111, 2'b00, 8'h08);
      exp_regs[127:96] = 32'hDEADBEEF;
      bus.S_AXI_ARADDR  = 32'h0C;
      bus.S_AXI_ARVALID = 1'b1;
      step();
      bus.S_AXI_ARVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t5_rvalid", bus.S_AXI_RVALID, 1'b1);
         chk("t5_rdata", bus.S_AXI_RDATA, 32'hDEADBEEF);
         chk("t5_arready", bus.S_AXI_ARREADY, 1'b0);
         step();
      end
      bus.S_AXI_RREADY = 1'b1;
      step();
      bus.S_AXI_RREADY = 1'b0;
      chk("t5_rvalid_done", bus.S_AXI_RVALID, 1'b0);
      chk("t5_arready_done", bus.S_AXI_ARREADY, 1'b1);

      // 6: out-of-range write and read
      write("t6w", 32'h100, 32'hFFFFFFFF, 4'b1111, oor_resp, 8'h00);
      chk("t6_regs", reg_out, exp_regs);
      read("t6r", 32'h100, 32'h0, oor_resp);
      read("t6edge", 32'h1C, 32'h0, 2'b00);
      read("t6edge_oor", 32'h20, 32'h0, oor_resp);

      // 7: reset after AW only drops the half-built write
      bus.S_AXI_AWADDR  = 32'h00;
      bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      chk("t7_aw_held", bus.S_AXI_AWREADY, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("t7_bvalid", bus.S_AXI_BVALID, 1'b0);
      chk("t7_regs", reg_out, 256'h0);
      chk("t7_awready", bus.S_AXI_AWREADY, 1'b1);
      chk("t7_wready", bus.S_AXI_WREADY, 1'b1);
      chk("t7_arready", bus.S_AXI_ARREADY, 1'b1);
      step();
      rst_n = 1'b1;
      step();
      exp_regs = '0;
      // A lone W must not commit against the discarded AW
      bus.S_AXI_WDATA  = 32'hCAFEF00D;
      bus.S_AXI_WSTRB  = 4'b1111;
      bus.S_AXI_WVALID = 1'b1;
      step();
      bus.S_AXI_WVALID = 1'b0;
      step();
      chk("t7_lone_w_bvalid", bus.S_AXI_BVALID, 1'b0);
      chk("t7_lone_w_regs", reg_out, 256'h0);
      bus.S_AXI_AWADDR  = 32'h00;
      bus.S_AXI_AWVALID = 1'b1;
      step();
      bus.S_AXI_AWVALID = 1'b0;
      step();
      chk("t7_late_aw_bvalid", bus.S_AXI_BVALID, 1'b1);
      chk("t7_late_aw_pulse", reg_wr_pulse, 8'h01);
      bus.S_AXI_BREADY = 1'b1;
      step();
      bus.S_AXI_BREADY = 1'b0;
      exp_regs[31:0] = 32'hCAFEF00D;
      write("t7w", 32'h00, 32'h12345678, 4'b1111, 2'b00, 8'h01);
      exp_regs[31:0] = 32'h12345678;
      chk("t7_regs_after", reg_out, exp_regs);
      read("t7r", 32'h00, 32'h12345678, 2'b00);

      // WSTRB=0000 still pulses but leaves data alone
      write("strb0", 32'h14, 32'h99999999, 4'b0000, 2'b00, 8'h20);
      chk("strb0_regs", reg_out, exp_regs);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
